// File: rtl/systolic_seq_ctrl_if.sv
// Command/array-control bundle for systolic_seq_ctrl; master = upstream controller, slave = sequencer.
// Perf counter signals exist only when SYS_PERF_CNT_EN is defined.
interface systolic_seq_ctrl_if #(
  parameter int N      = 3,
  parameter int ROW_W  = 8,
  parameter int ADDR_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [ROW_W-1:0]  cmd_rows;
  logic [ADDR_W-1:0] cmd_acc_addr;
  logic              cmd_acc_clear;
  logic              cmd_reuse_weights;
  logic              abort;
  logic              busy;
  logic              done;
  logic              err_mode;
  logic              en_weight_pass;
  logic [N-1:0]      en_capture;
  logic              systolic_active;
  logic              acc_wr_en;
  logic [ADDR_W-1:0] acc_wr_addr;
  logic              acc_accumulate;
  logic              acc_clear;
`ifdef SYS_PERF_CNT_EN
  logic [31:0]       perf_busy_cycles;
  logic [31:0]       perf_cmds;

  modport master (
    output cmd_valid, cmd_mode, cmd_rows, cmd_acc_addr, cmd_acc_clear, cmd_reuse_weights, abort,
    input  cmd_ready, busy, done, err_mode, en_weight_pass, en_capture, systolic_active,
           acc_wr_en, acc_wr_addr, acc_accumulate, acc_clear, perf_busy_cycles, perf_cmds
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_rows, cmd_acc_addr, cmd_acc_clear, cmd_reuse_weights, abort,
    output cmd_ready, busy, done, err_mode, en_weight_pass, en_capture, systolic_active,
           acc_wr_en, acc_wr_addr, acc_accumulate, acc_clear, perf_busy_cycles, perf_cmds
  );
`else
  modport master (
    output cmd_valid, cmd_mode, cmd_rows, cmd_acc_addr, cmd_acc_clear, cmd_reuse_weights, abort,
    input  cmd_ready, busy, done, err_mode, en_weight_pass, en_capture, systolic_active,
           acc_wr_en, acc_wr_addr, acc_accumulate, acc_clear
  );
  modport slave (
    input  cmd_valid, cmd_mode, cmd_rows, cmd_acc_addr, cmd_acc_clear, cmd_reuse_weights, abort,
    output cmd_ready, busy, done, err_mode, en_weight_pass, en_capture, systolic_active,
           acc_wr_en, acc_wr_addr, acc_accumulate, acc_clear
  );
`endif
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: LOAD -> COMPUTE -> DRAIN -> DONE.
// Optional SYS_PERF_CNT_EN adds saturating busy-cycle and completed-command counters.
module systolic_seq_ctrl #(
  parameter int N      = 3,
  parameter int ROW_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int CW = ROW_W + 5;
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_mode;
  logic [ROW_W-1:0]  r_rows;
  logic [ADDR_W-1:0] r_base;
  logic              r_clear;
  logic              r_first;
  logic              r_wv;

  logic              w_accept;
  logic [CW-1:0]     w_rows_ext;
  logic [CW-1:0]     w_last_beat;
  logic [CW-1:0]     w_off;
  logic              w_wr_en;

  assign w_rows_ext  = {{5{1'b0}}, r_rows};
  assign w_last_beat = w_rows_ext + CW'(N - 2);
  assign w_accept    = bus.cmd_valid && bus.cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_rows  <= '0;
      r_base  <= '0;
      r_clear <= 1'b0;
      r_first <= 1'b0;
      r_wv    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (r_state != S_IDLE && bus.abort) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_wv    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_mode  <= bus.cmd_mode;
              r_rows  <= bus.cmd_rows;
              r_base  <= bus.cmd_acc_addr;
              r_clear <= bus.cmd_acc_clear;
              r_first <= 1'b1;
              r_cnt   <= '0;
              if (bus.cmd_mode[0] || bus.cmd_rows == '0)
                r_state <= S_DONE;
              else if (bus.cmd_reuse_weights && r_wv)
                r_state <= S_COMPUTE;
              else
                r_state <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (r_cnt == NM1) begin
              r_cnt   <= '0;
              r_wv    <= 1'b1;
              r_state <= S_COMPUTE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          // The beat counter keeps running from COMPUTE into DRAIN so write addressing stays continuous.
          S_COMPUTE: begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == w_rows_ext - CW'(1))
              r_state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (r_cnt == w_last_beat) begin
              r_cnt   <= '0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_off   = r_cnt - NM1;
  assign w_wr_en = (r_state == S_COMPUTE || r_state == S_DRAIN) &&
                   (r_cnt >= NM1) && (r_cnt <= w_last_beat);

  assign bus.cmd_ready       = (r_state == S_IDLE) && !bus.abort;
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.done            = (r_state == S_DONE);
  assign bus.err_mode        = (r_state == S_DONE) && r_mode[0];
  assign bus.en_weight_pass  = (r_state == S_LOAD);
  assign bus.systolic_active = (r_state == S_COMPUTE);
  assign bus.acc_wr_en       = w_wr_en;
  assign bus.acc_accumulate  = w_wr_en && (r_mode == 2'b10);
  assign bus.acc_clear       = r_first && r_clear && !r_mode[0];

  always_comb begin
    bus.en_capture  = '0;
    bus.acc_wr_addr = '0;
    if (r_state == S_LOAD)
      bus.en_capture = N'(1) << r_cnt;
    if (w_wr_en)
      bus.acc_wr_addr = r_base + ADDR_W'(w_off);
  end

`ifdef SYS_PERF_CNT_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_cmds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_busy <= '0;
      r_perf_cmds <= '0;
    end else begin
      if (r_state != S_IDLE && r_perf_busy != '1)
        r_perf_busy <= r_perf_busy + 32'd1;
      if (r_state == S_DONE && r_perf_cmds != '1)
        r_perf_cmds <= r_perf_cmds + 32'd1;
    end
  end

  assign bus.perf_busy_cycles = r_perf_busy;
  assign bus.perf_cmds        = r_perf_cmds;
`else
  // Performance counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=3): per-cycle expected output vectors are queued
// when a command is issued and compared one per cycle on the falling edge.
module tb_systolic_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  systolic_seq_ctrl_if #(.N(3), .ROW_W(8), .ADDR_W(8)) bus ();

  systolic_seq_ctrl #(.N(3), .ROW_W(8), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       done;
    logic       err;
    logic       wp;
    logic [2:0] cap;
    logic       sa;
    logic       wen;
    logic [7:0] addr;
    logic       acc;
    logic       clr;
  } vec_t;

  vec_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   wv    = 1'b0;
  vec_t idle_v;
  vec_t blocked_v;

  function automatic vec_t obs();
    vec_t o;
    o.rdy  = bus.cmd_ready;
    o.busy = bus.busy;
    o.done = bus.done;
    o.err  = bus.err_mode;
    o.wp   = bus.en_weight_pass;
    o.cap  = bus.en_capture;
    o.sa   = bus.systolic_active;
    o.wen  = bus.acc_wr_en;
    o.addr = bus.acc_wr_addr;
    o.acc  = bus.acc_accumulate;
    o.clr  = bus.acc_clear;
    return o;
  endfunction

  task automatic chk(input string tag, input vec_t exp);
    vec_t o;
    o = obs();
    n_vec++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  // Reference trace: one expected vector per cycle from the accept edge to DONE.
  function automatic void gen(input logic [1:0] mode, input logic [7:0] rows, input logic [7:0] base,
                              input logic clr, input logic reuse);
    vec_t v;
    bit   first = 1'b1;
    if (mode[0] || rows == 8'd0) begin
      v = '0; v.busy = 1'b1; v.done = 1'b1; v.err = mode[0]; v.clr = clr && !mode[0];
      q.push_back(v);
      return;
    end
    if (!(reuse && wv)) begin
      for (int k = 0; k < 3; k++) begin
        v = '0; v.busy = 1'b1; v.wp = 1'b1; v.cap = 3'(1 << k); v.clr = first && clr;
        first = 1'b0;
        q.push_back(v);
      end
      wv = 1'b1;
    end
    for (int t = 0; t <= int'(rows) + 1; t++) begin
      v = '0; v.busy = 1'b1; v.sa = (t < int'(rows)); v.clr = first && clr;
      first = 1'b0;
      if (t >= 2) begin
        v.wen  = 1'b1;
        v.addr = base + 8'(t - 2);
        v.acc  = (mode == 2'b10);
      end
      q.push_back(v);
    end
    v = '0; v.busy = 1'b1; v.done = 1'b1;
    q.push_back(v);
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
  task automatic run_cmd(input string name, input logic [1:0] mode, input logic [7:0] rows,
                         input logic [7:0] base, input logic clr, input logic reuse,
                         input int abort_at, input int rst_at);
    vec_t e;
    int   idx;
    bus.cmd_valid = 1'b1; bus.cmd_mode = mode; bus.cmd_rows = rows;
    bus.cmd_acc_addr = base; bus.cmd_acc_clear = clr; bus.cmd_reuse_weights = reuse;
    @(negedge clk);
    chk({name, "_ready"}, idle_v);
    gen(mode, rows, base, clr, reuse);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 2'b01; bus.cmd_rows = 8'hA5;
    bus.cmd_acc_addr = 8'h5A; bus.cmd_acc_clear = 1'b0; bus.cmd_reuse_weights = 1'b0;
    idx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (idx == abort_at) bus.abort = 1'b1;
      if (idx == rst_at) begin
        #2 rst = 1'b1;
        #1 chk($sformatf("%s_rst_async", name), idle_v);
`ifdef SYS_PERF_CNT_EN
        n_vec++;
        assert (bus.perf_busy_cycles === 32'd0 && bus.perf_cmds === 32'd0) else begin
          n_err++;
          $error("FAIL perf_rst observed=%h/%h expected=0/0", bus.perf_busy_cycles, bus.perf_cmds);
        end
`endif
        wv = 1'b0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
        chk($sformatf("%s_cyc%0d", name, idx), e);
        if (idx == abort_at) begin
          @(posedge clk);
          #1 bus.abort = 1'b0;
          q.delete();
          wv = 1'b0;
          @(negedge clk);
          chk({name, "_post_abort"}, idle_v);
        end
      end
      @(posedge clk);
      #1;
      idx++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle_v = '0; idle_v.rdy = 1'b1;
    blocked_v = '0;
    bus.cmd_valid = 1'b0; bus.cmd_mode = 2'b00; bus.cmd_rows = 8'd0;
    bus.cmd_acc_addr = 8'd0; bus.cmd_acc_clear = 1'b0; bus.cmd_reuse_weights = 1'b0;
    bus.abort = 1'b0;

    #2 chk("reset", idle_v);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle", idle_v);
    @(posedge clk);
    #1;

    run_cmd("mm_ovw",    2'b00, 8'd4, 8'h10, 1'b1, 1'b0, -1, -1);
    run_cmd("acc_reuse", 2'b10, 8'd2, 8'hFF, 1'b0, 1'b1, -1, -1);
    run_cmd("abort",     2'b00, 8'd4, 8'h20, 1'b0, 1'b1,  1, -1);
    run_cmd("reload",    2'b10, 8'd1, 8'h30, 1'b1, 1'b1, -1, -1);

    // Abort while idle only blocks acceptance.
    bus.abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_rows = 8'd3; bus.cmd_mode = 2'b00;
    @(negedge clk);
    chk("idle_abort_blocks", blocked_v);
    @(posedge clk);
    #1 bus.abort = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("idle_abort_no_accept", idle_v);
    @(posedge clk);
    #1;

    run_cmd("rsvd11",    2'b11, 8'd5, 8'h40, 1'b1, 1'b0, -1, -1);
    run_cmd("rsvd01_r0", 2'b01, 8'd0, 8'h40, 1'b0, 1'b0, -1, -1);
    run_cmd("rows0",     2'b00, 8'd0, 8'h50, 1'b1, 1'b0, -1, -1);
    run_cmd("rst_drain", 2'b00, 8'd3, 8'h60, 1'b0, 1'b0, -1,  6);
    @(negedge clk);
    chk("after_rst_idle", idle_v);
    @(posedge clk);
    #1;
    run_cmd("post_rst",  2'b00, 8'd2, 8'hFE, 1'b1, 1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
